// File: rtl/bn_serial_alu_ctrl_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: operation codes and FSM states.
package bn_serial_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/bn_serial_alu_ctrl_if.sv
// Request/result bundle of the bit-serial ALU; master issues operations, slave executes them.
// Optional zero flag present when BN_ALU_ZERO_FLAG_EN is defined.
interface bn_serial_alu_ctrl_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         carry_out;
  logic         overflow;
`ifdef BN_ALU_ZERO_FLAG_EN
  logic         zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow, zero
  );
`else
  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow
  );
`endif
endinterface

// File: rtl/bn_serial_alu_ctrl_b1_fa_slice.sv
// Single-bit full adder reused every cycle by the serial ALU.
module b1_fa_slice (
  input  logic x_i,
  input  logic y_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = x_i ^ y_i ^ cin_i;
  assign cout_o = (x_i & y_i) | (cin_i & (x_i ^ y_i));
endmodule

// File: rtl/bn_serial_alu_ctrl.sv
// Bit-serial N-bit ADD/SUB/SLT/SLTU sequencer: one full-adder slice stepped LSB-first over N cycles.
// Optional zero flag enabled by defining BN_ALU_ZERO_FLAG_EN.
module bn_serial_alu_ctrl
  import bn_serial_alu_ctrl_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input logic                clk,
  input logic                rst,
  bn_serial_alu_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(N);

  state_e        state_q, state_d;
  alu_op_e       op_q, op_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [N-1:0]  sum_sh_q, sum_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  result_q, result_d;
  logic          carry_out_q, carry_out_d;
  logic          overflow_q, overflow_d;
`ifdef BN_ALU_ZERO_FLAG_EN
  logic          zacc_q, zacc_d;
  logic          zero_q, zero_d;
`endif

  logic fa_x, fa_y, fa_cin, fa_s, fa_cout;
  logic ovf;

  // Subtraction reuses the adder as A + ~B + 1; the +1 enters through the initial carry.
  assign fa_x   = a_sh_q[0];
  assign fa_y   = b_sh_q[0] ^ (op_q != OP_ADD);
  assign fa_cin = carry_q;

  b1_fa_slice u_fa (
    .x_i    (fa_x),
    .y_i    (fa_y),
    .cin_i  (fa_cin),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef BN_ALU_ZERO_FLAG_EN
      zacc_q      <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
`ifdef BN_ALU_ZERO_FLAG_EN
      zacc_q      <= zacc_d;
      zero_q      <= zero_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    ovf         = 1'b0;
`ifdef BN_ALU_ZERO_FLAG_EN
    zacc_d      = zacc_q;
    zero_d      = zero_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = alu_op_e'(bus.op);
          cnt_d   = '0;
          carry_d = (bus.op != OP_ADD);
`ifdef BN_ALU_ZERO_FLAG_EN
          zacc_d  = 1'b1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        sum_sh_d = {fa_s, sum_sh_q[N-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
`ifdef BN_ALU_ZERO_FLAG_EN
        zacc_d   = zacc_q & ~fa_s;
`endif
        if (cnt_q == CW'(N - 1)) begin
          state_d     = S_DONE;
          ovf         = fa_cin ^ fa_cout;
          carry_out_d = fa_cout;
          overflow_d  = ovf;
          // fa_s is the MSB of the final difference on this edge.
          case (op_q)
            OP_SLT: begin
              result_d    = '0;
              result_d[0] = fa_s ^ ovf;
            end
            OP_SLTU: begin
              result_d    = '0;
              result_d[0] = ~fa_cout;
            end
            default: result_d = sum_sh_d;
          endcase
`ifdef BN_ALU_ZERO_FLAG_EN
          zero_d = zacc_q & ~fa_s;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
`ifdef BN_ALU_ZERO_FLAG_EN
  assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_bn_serial_alu_ctrl.sv
// Self-checking bench for bn_serial_alu_ctrl: directed cases plus randomized traffic vs an arithmetic model.
module tb_bn_serial_alu_ctrl;
  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bn_serial_alu_ctrl_if #(.N(N)) bus ();

  bn_serial_alu_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending-cycle countdown plus plain integer arithmetic.
  int           m_left = 0;
  bit           m_done = 0;
  logic [N-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [1:0]   m_op = 2'b00;
  bit           m_co = 0, m_ov = 0, m_z = 0;

  task automatic model_eval(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                            output logic [N-1:0] res, output bit co, output bit ov, output bit z);
    logic [N:0]   full;
    logic [N-1:0] bb;
    bb   = (op == 2'b00) ? b : ~b;
    full = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, (op != 2'b00)};
    co   = full[N];
    ov   = (a[N-1] == bb[N-1]) && (full[N-1] != a[N-1]);
    z    = (full[N-1:0] == '0);
    case (op)
      2'b10:   res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      2'b11:   res = {{(N-1){1'b0}}, (a < b)};
      default: res = full[N-1:0];
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_done = 0; m_res = '0; m_co = 0; m_ov = 0; m_z = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        model_eval(m_op, m_a, m_b, m_res, m_co, m_ov, m_z);
        m_done = 1;
      end
    end else begin
      m_done = 0;
      if (bus.start === 1'b1) begin
        m_a = bus.a; m_b = bus.b; m_op = bus.op;
        m_left = N;
      end
    end
  end

  always @(negedge clk) begin
    check("busy",      {{N{1'b0}}, bus.busy},      {{N{1'b0}}, (m_left > 0)});
    check("done",      {{N{1'b0}}, bus.done},      {{N{1'b0}}, m_done});
    check("result",    {1'b0, bus.result},         {1'b0, m_res});
    check("carry_out", {{N{1'b0}}, bus.carry_out}, {{N{1'b0}}, m_co});
    check("overflow",  {{N{1'b0}}, bus.overflow},  {{N{1'b0}}, m_ov});
`ifdef BN_ALU_ZERO_FLAG_EN
    check("zero",      {{N{1'b0}}, bus.zero},      {{N{1'b0}}, m_z});
`endif
  end

  // Issue one operation at the current negedge and return at the negedge where done is seen.
  task automatic do_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit poke, output int busy_cyc);
    bit seen;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = N'($urandom); bus.b = N'($urandom); bus.op = 2'($urandom);
    busy_cyc = 0;
    seen = 0;
    for (int i = 0; i < int'(N) + 4; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
      if (bus.busy === 1'b1) busy_cyc++;
      if (poke && i == 10) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd999;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_seen", {{N{1'b0}}, seen}, {{N{1'b0}}, 1'b1});
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return {1'b0, {(N-1){1'b1}}};
      4:       return N'($urandom_range(0, 40));
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    int bc;
    int dcount;
    logic [N-1:0] ra;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_result", {1'b0, bus.result}, '0);
    check("rst_busy", {{N{1'b0}}, bus.busy}, '0);
    rst = 1'b0;
    @(negedge clk);

    do_op(2'b00, 32'd25, 32'd5, 0, bc);
    check("add_busy_cycles", (N+1)'(bc), (N+1)'(32));
    check("add_result", {1'b0, bus.result}, {1'b0, 32'd30});
    check("add_co", {{N{1'b0}}, bus.carry_out}, '0);
    check("add_ov", {{N{1'b0}}, bus.overflow}, '0);
    @(negedge clk);

    do_op(2'b10, 32'd25, 32'hFFFF_FFFB, 0, bc);
    check("slt_pos_neg", {1'b0, bus.result}, '0);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd25, 0, bc);
    check("slt_b2b_busy", (N+1)'(bc), (N+1)'(32));
    check("slt_neg_pos", {1'b0, bus.result}, {{N{1'b0}}, 1'b1});
    @(negedge clk);

    do_op(2'b11, 32'hFFFF_FFFB, 32'd25, 0, bc);
    check("sltu", {1'b0, bus.result}, '0);
    @(negedge clk);
    do_op(2'b01, 32'd5, 32'd25, 0, bc);
    check("sub_result", {1'b0, bus.result}, {1'b0, 32'hFFFF_FFEC});
    check("sub_co", {{N{1'b0}}, bus.carry_out}, '0);
    @(negedge clk);

    do_op(2'b00, 32'h7FFF_FFFF, 32'd1, 0, bc);
    check("add_ovf_result", {1'b0, bus.result}, {1'b0, 32'h8000_0000});
    check("add_ovf_ov", {{N{1'b0}}, bus.overflow}, {{N{1'b0}}, 1'b1});
    check("add_ovf_co", {{N{1'b0}}, bus.carry_out}, '0);
    @(negedge clk);
    do_op(2'b00, 32'hFFFF_FFFF, 32'd1, 0, bc);
    check("add_wrap_result", {1'b0, bus.result}, '0);
    check("add_wrap_co", {{N{1'b0}}, bus.carry_out}, {{N{1'b0}}, 1'b1});
    check("add_wrap_ov", {{N{1'b0}}, bus.overflow}, '0);
`ifdef BN_ALU_ZERO_FLAG_EN
    check("add_wrap_zero", {{N{1'b0}}, bus.zero}, {{N{1'b0}}, 1'b1});
`endif
    @(negedge clk);

    do_op(2'b00, 32'd25, 32'd5, 1, bc);
    check("ignored_start_result", {1'b0, bus.result}, {1'b0, 32'd30});
    @(negedge clk);

    // Asynchronous reset mid-RUN.
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {{N{1'b0}}, bus.busy}, '0);
    check("arst_done", {{N{1'b0}}, bus.done}, '0);
    check("arst_result", {1'b0, bus.result}, '0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcount++;
    end
    check("no_done_after_rst", (N+1)'(dcount), '0);
    do_op(2'b00, 32'd100, 32'd23, 0, bc);
    check("post_rst_add", {1'b0, bus.result}, {1'b0, 32'd123});
    @(negedge clk);

    // Randomized traffic: inputs change every cycle, start requested at random.
    repeat (3000) begin
      ra = pick();
      bus.a     = ra;
      bus.b     = ($urandom_range(0, 4) == 0) ? ra : pick();
      bus.op    = 2'($urandom);
      bus.start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (N + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
